// File: rtl/pc_seq_pkg.sv
// ==========================================================================
// pc_seq_pkg : opcodes and FSM state encoding for the fetch sequencer. Rev 1.0
// ==========================================================================
`default_nettype none

package pc_seq_pkg;

  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_JMP = 1;
  localparam int unsigned OP_JZ  = 2;
  localparam int unsigned OP_DLY = 3;
  localparam int unsigned OP_HLT = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_DELAY = 3'd3,
    S_HALT  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_sequencer_if.sv
// ==========================================================================
// pc_fetch_sequencer_if : program-counter / ROM / control bundle. Rev 1.0
// ==========================================================================
`default_nettype none

interface pc_fetch_sequencer_if #(
  parameter int AW  = 4,
  parameter int OPW = 4
);
  logic                start;
  logic [AW-1:0]       PC;
  logic [OPW+AW-1:0]   instr;
  logic                zero;
  logic                PCload;
  logic                PCinc;
  logic [AW-1:0]       load_in;
  logic                busy;
  logic                halted;

  modport master (
    input  start, PC, instr, zero,
    output PCload, PCinc, load_in, busy, halted
  );

  modport slave (
    output start, PC, instr, zero,
    input  PCload, PCinc, load_in, busy, halted
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_sequencer_dly.sv
// ==========================================================================
// dly_counter : AW-bit loadable down-counter with a count==1 flag. Rev 1.0
// ==========================================================================
`default_nettype none

module dly_counter #(
  parameter int AW = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_load,
  input  wire logic [AW-1:0] i_val,
  input  wire logic          i_dec,
  output logic               o_is_one
);
  logic [AW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_val;
    else if (i_dec)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_is_one = (r_cnt == AW'(1));
endmodule

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
// ==========================================================================
// pc_fetch_sequencer : 2-cycle fetch/execute unit driving PC load/inc. Rev 1.0
// ==========================================================================
`default_nettype none

module pc_fetch_sequencer #(
  parameter int AW  = 4,
  parameter int OPW = 4
) (
  input  wire logic               clk,
  input  wire logic               reset,
  pc_fetch_sequencer_if.master    bus
);
  import pc_seq_pkg::*;

  state_e              r_state;
  state_e              w_state_next;
  logic [OPW+AW-1:0]   r_ir;
  logic [OPW-1:0]      w_op;
  logic [AW-1:0]       w_arg;
  logic                w_pcload;
  logic                w_pcinc;
  logic [AW-1:0]       w_load_in;
  logic                w_dly_load;
  logic                w_dly_dec;
  logic                w_dly_one;

  assign w_op  = r_ir[OPW+AW-1:AW];
  assign w_arg = r_ir[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ir <= '0;
    else if (r_state == S_FETCH)
      r_ir <= bus.instr;
  end

  dly_counter #(.AW(AW)) u_dly (
    .clk      (clk),
    .rst      (reset),
    .i_load   (w_dly_load),
    .i_val    (w_arg),
    .i_dec    (w_dly_dec),
    .o_is_one (w_dly_one)
  );

  // Strobes come only from registered state/ir/dcnt (and zero for JZ), never instr.
  always_comb begin
    w_state_next = r_state;
    w_pcload     = 1'b0;
    w_pcinc      = 1'b0;
    w_load_in    = '0;
    w_dly_load   = 1'b0;
    w_dly_dec    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        w_state_next = S_FETCH;
        case (w_op)
          OPW'(OP_NOP): w_pcinc = 1'b1;
          OPW'(OP_JMP): begin
            w_pcload  = 1'b1;
            w_load_in = w_arg;
          end
          OPW'(OP_JZ): begin
            if (bus.zero) begin
              w_pcload  = 1'b1;
              w_load_in = w_arg;
            end else begin
              w_pcinc = 1'b1;
            end
          end
          OPW'(OP_DLY): begin
            if (w_arg == '0) begin
              w_pcinc = 1'b1;
            end else begin
              w_dly_load   = 1'b1;
              w_state_next = S_DELAY;
            end
          end
          OPW'(OP_HLT): w_state_next = S_HALT;
          default:      w_pcinc = 1'b1;
        endcase
      end
      S_DELAY: begin
        w_dly_dec = 1'b1;
        if (w_dly_one) begin
          w_pcinc      = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.PCload  = w_pcload;
  assign bus.PCinc   = w_pcinc;
  assign bus.load_in = w_load_in;
  assign bus.busy    = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_DELAY);
  assign bus.halted  = (r_state == S_HALT);
endmodule

`default_nettype wire
